// File: rtl/r_type_chk_pkg.sv
// Shared types for the darkriscv retirement tracker:
// opcode/funct constants, ALU op and check-result enums, queue entry.
package r_type_chk_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_MISMATCH    = 3'd1,
        ERR_RD_MISMATCH = 3'd2,
        ERR_UNEXPECTED  = 3'd3,
        ERR_TIMEOUT     = 3'd4,
        ERR_OVERFLOW    = 3'd5
    } err_kind_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic        is_r;
        logic [31:0] exp;
    } entry_t;

    function automatic logic writes_rd(input logic [6:0] opc);
        return opc inside {OPC_R, OPC_IMM, OPC_LOAD, OPC_LUI,
                           OPC_AUIPC, OPC_JAL, OPC_JALR};
    endfunction

endpackage

// File: rtl/r_type_ref_alu.sv
// Reference ALU for RV32I R-type: decodes funct3/funct7 and
// computes the result the core should write back.
module r_type_ref_alu
    import r_type_chk_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        legal
);

    alu_op_e    op;
    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        op    = ALU_ADD;
        legal = 1'b0;
        if (funct7 == F7_BASE) begin
            legal = 1'b1;
            unique case (funct3)
                F3_ADD:  op = ALU_ADD;
                F3_SLL:  op = ALU_SLL;
                F3_SLT:  op = ALU_SLT;
                F3_SLTU: op = ALU_SLTU;
                F3_XOR:  op = ALU_XOR;
                F3_SRL:  op = ALU_SRL;
                F3_OR:   op = ALU_OR;
                F3_AND:  op = ALU_AND;
                default: op = ALU_ADD;
            endcase
        end else if (funct7 == F7_ALT) begin
            unique case (funct3)
                F3_ADD: begin
                    op    = ALU_SUB;
                    legal = 1'b1;
                end
                F3_SRL: begin
                    op    = ALU_SRA;
                    legal = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = 32'($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/r_type_retire_tracker.sv
// In-order retirement tracker: queues rd-writing instructions at
// issue and checks them against register-file writebacks.
module r_type_retire_tracker
    import r_type_chk_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                     CLK,
    input  logic                     RES,
    input  logic [31:0]              IDATA,
    input  logic                     IVALID,
    input  logic                     FLUSH,
    input  logic [31:0]              RS1_VAL,
    input  logic [31:0]              RS2_VAL,
    input  logic                     WB_VALID,
    input  logic [4:0]               WB_RD,
    input  logic [31:0]              WB_DATA,
    output logic                     CHK_VALID,
    output logic                     CHK_PASS,
    output logic [2:0]               CHK_KIND,
    output logic [31:0]              CHK_EXP,
    output logic [31:0]              CHK_ACT,
    output logic [CNT_W-1:0]         PASS_CNT,
    output logic [CNT_W-1:0]         ERR_CNT,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVF
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int AGE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACTIVE,
        ST_OVERFLOWED
    } state_e;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [AGE_W-1:0] age_q;
    state_e           state_q;

    logic [6:0]  opc;
    logic [4:0]  rd;
    logic        is_r;
    logic [31:0] alu_res;
    logic        alu_legal;

    assign opc  = IDATA[6:0];
    assign rd   = IDATA[11:7];
    assign is_r = (opc == OPC_R);

    r_type_ref_alu u_alu (
        .funct3 (IDATA[14:12]),
        .funct7 (IDATA[31:25]),
        .a      (RS1_VAL),
        .b      (RS2_VAL),
        .result (alu_res),
        .legal  (alu_legal)
    );

    logic [PTR_W-1:0] level;
    logic [PTR_W-1:0] level_n;
    logic             empty;
    logic             full;
    entry_t           head_e;

    assign level  = tail_q - head_q;
    assign empty  = (level == '0);
    assign full   = (level == PTR_W'(DEPTH));
    assign head_e = mem[head_q[IDX_W-1:0]];

    logic push_req;
    logic push;
    logic wb_ev;
    logic wb_pop;
    logic unexp;
    logic tmo;
    logic pop;
    logic ovf_ev;
    logic rd_bad;
    logic data_bad;
    logic pass_inc;
    logic err_inc;

    assign push_req = IVALID && !FLUSH && writes_rd(opc)
                      && (rd != 5'd0) && (!is_r || alu_legal);
    assign wb_ev    = WB_VALID && (WB_RD != 5'd0);
    assign wb_pop   = wb_ev && !empty;
    assign unexp    = wb_ev && empty;
    // A writeback in the same cycle beats the timeout.
    assign tmo      = !empty && !wb_ev
                      && (age_q == AGE_W'(TIMEOUT));
    assign pop      = wb_pop || tmo;
    assign ovf_ev   = push_req && full && !pop;
    assign push     = push_req && !ovf_ev;

    assign rd_bad   = (WB_RD != head_e.rd);
    assign data_bad = head_e.is_r && (WB_DATA !== head_e.exp);
    assign pass_inc = wb_pop && !rd_bad && !data_bad;
    assign err_inc  = unexp || (wb_pop && (rd_bad || data_bad))
                      || tmo || ovf_ev;

    always_comb begin
        level_n = level;
        if (FLUSH)
            level_n = '0;
        else
            level_n = level + PTR_W'(push) - PTR_W'(pop);
    end

    logic        rep_valid;
    logic        rep_pass;
    err_kind_e   rep_kind;
    logic [31:0] rep_exp;
    logic [31:0] rep_act;

    always_comb begin
        rep_valid = 1'b0;
        rep_pass  = 1'b0;
        rep_kind  = ERR_NONE;
        rep_exp   = '0;
        rep_act   = '0;
        if (wb_ev) begin
            rep_valid = 1'b1;
            rep_act   = WB_DATA;
            if (empty) begin
                rep_kind = ERR_UNEXPECTED;
            end else begin
                if (head_e.is_r)
                    rep_exp = head_e.exp;
                if (rd_bad)
                    rep_kind = ERR_RD_MISMATCH;
                else if (data_bad)
                    rep_kind = ERR_MISMATCH;
                else
                    rep_pass = 1'b1;
            end
        end else if (tmo) begin
            rep_valid = 1'b1;
            rep_kind  = ERR_TIMEOUT;
            if (head_e.is_r)
                rep_exp = head_e.exp;
        end else if (ovf_ev) begin
            rep_valid = 1'b1;
            rep_kind  = ERR_OVERFLOW;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[tail_q[IDX_W-1:0]] <= '{rd: rd, is_r: is_r,
                                         exp: is_r ? alu_res : '0};
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            head_q    <= '0;
            tail_q    <= '0;
            age_q     <= '0;
            state_q   <= ST_EMPTY;
            CHK_VALID <= 1'b0;
            CHK_PASS  <= 1'b0;
            CHK_KIND  <= ERR_NONE;
            CHK_EXP   <= '0;
            CHK_ACT   <= '0;
            PASS_CNT  <= '0;
            ERR_CNT   <= '0;
        end else begin
            // Flush discards whatever survives this cycle's pop.
            if (FLUSH) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                head_q <= head_q + PTR_W'(pop);
                tail_q <= tail_q + PTR_W'(push);
            end

            if (pop || FLUSH || empty)
                age_q <= '0;
            else if (age_q != AGE_W'(TIMEOUT))
                age_q <= age_q + 1'b1;

            if (ovf_ev)
                state_q <= ST_OVERFLOWED;
            else if (state_q != ST_OVERFLOWED)
                state_q <= (level_n == '0) ? ST_EMPTY : ST_ACTIVE;

            CHK_VALID <= rep_valid;
            CHK_PASS  <= rep_pass;
            CHK_KIND  <= rep_kind;
            CHK_EXP   <= rep_exp;
            CHK_ACT   <= rep_act;

            if (pass_inc && (PASS_CNT != '1))
                PASS_CNT <= PASS_CNT + 1'b1;
            if (err_inc && (ERR_CNT != '1))
                ERR_CNT <= ERR_CNT + 1'b1;
        end
    end

    assign LEVEL = level;
    assign OVF   = (state_q == ST_OVERFLOWED);

endmodule

// File: tb/tb_r_type_retire_tracker.sv
// Directed bench for r_type_retire_tracker with hand-computed
// expectations for R-type checks, overflow, timeout and flush.
module tb_r_type_retire_tracker;

    logic        CLK = 1'b0;
    logic        RES;
    logic [31:0] IDATA;
    logic        IVALID;
    logic        FLUSH;
    logic [31:0] RS1_VAL;
    logic [31:0] RS2_VAL;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic [31:0] WB_DATA;
    logic        CHK_VALID;
    logic        CHK_PASS;
    logic [2:0]  CHK_KIND;
    logic [31:0] CHK_EXP;
    logic [31:0] CHK_ACT;
    logic [15:0] PASS_CNT;
    logic [15:0] ERR_CNT;
    logic [2:0]  LEVEL;
    logic        OVF;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] K_NONE  = 3'd0;
    localparam logic [2:0] K_MIS   = 3'd1;
    localparam logic [2:0] K_RDMIS = 3'd2;
    localparam logic [2:0] K_UNEXP = 3'd3;
    localparam logic [2:0] K_TMO   = 3'd4;
    localparam logic [2:0] K_OVF   = 3'd5;

    r_type_retire_tracker dut (
        .CLK       (CLK),
        .RES       (RES),
        .IDATA     (IDATA),
        .IVALID    (IVALID),
        .FLUSH     (FLUSH),
        .RS1_VAL   (RS1_VAL),
        .RS2_VAL   (RS2_VAL),
        .WB_VALID  (WB_VALID),
        .WB_RD     (WB_RD),
        .WB_DATA   (WB_DATA),
        .CHK_VALID (CHK_VALID),
        .CHK_PASS  (CHK_PASS),
        .CHK_KIND  (CHK_KIND),
        .CHK_EXP   (CHK_EXP),
        .CHK_ACT   (CHK_ACT),
        .PASS_CNT  (PASS_CNT),
        .ERR_CNT   (ERR_CNT),
        .LEVEL     (LEVEL),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7,
                                          input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lui(input logic [4:0] rd);
        return {20'h12345, rd, 7'b0110111};
    endfunction

    task automatic issue(input logic [31:0] ins,
                         input logic [31:0] a,
                         input logic [31:0] b);
        IDATA   = ins;
        RS1_VAL = a;
        RS2_VAL = b;
        IVALID  = 1'b1;
        tick();
        IVALID  = 1'b0;
    endtask

    task automatic wb(input logic [4:0]  rd,
                      input logic [31:0] d,
                      input logic        fl);
        WB_VALID = 1'b1;
        WB_RD    = rd;
        WB_DATA  = d;
        FLUSH    = fl;
        tick();
        WB_VALID = 1'b0;
        FLUSH    = 1'b0;
    endtask

    initial begin
        int got;
        int pulses;
        RES      = 1'b1;
        IDATA    = '0;
        IVALID   = 1'b0;
        FLUSH    = 1'b0;
        RS1_VAL  = '0;
        RS2_VAL  = '0;
        WB_VALID = 1'b0;
        WB_RD    = '0;
        WB_DATA  = '0;
        tick();
        tick();
        RES = 1'b0;
        check("rst_valid", CHK_VALID, 0);
        check("rst_level", LEVEL, 0);
        check("rst_cnt", {PASS_CNT, ERR_CNT}, 0);
        check("rst_ovf", OVF, 0);

        // ADD x3 = 5 + 7
        issue(rtype(7'h00, 3'b000, 5'd3), 32'd5, 32'd7);
        check("add_level", LEVEL, 1);
        check("add_novalid", CHK_VALID, 0);
        wb(5'd3, 32'd12, 1'b0);
        check("add_valid", CHK_VALID, 1);
        check("add_pass", CHK_PASS, 1);
        check("add_exp", CHK_EXP, 32'd12);
        check("add_act", CHK_ACT, 32'd12);
        check("add_pcnt", PASS_CNT, 1);
        check("add_level0", LEVEL, 0);

        // SUB x4 = 5 - 7, wrong data written back
        issue(rtype(7'h20, 3'b000, 5'd4), 32'd5, 32'd7);
        wb(5'd4, 32'hFFFF_FFFF, 1'b0);
        check("sub_pass", CHK_PASS, 0);
        check("sub_kind", CHK_KIND, K_MIS);
        check("sub_exp", CHK_EXP, 32'hFFFF_FFFE);
        check("sub_ecnt", ERR_CNT, 1);

        issue(rtype(7'h20, 3'b101, 5'd5), 32'h8000_0000, 32'd4);
        wb(5'd5, 32'hF800_0000, 1'b0);
        check("sra_pass", CHK_PASS, 1);
        check("sra_exp", CHK_EXP, 32'hF800_0000);

        issue(rtype(7'h00, 3'b011, 5'd6), 32'd1, 32'hFFFF_FFFF);
        wb(5'd6, 32'd1, 1'b0);
        check("sltu_pass", CHK_PASS, 1);
        check("sltu_exp", CHK_EXP, 1);
        check("sltu_pcnt", PASS_CNT, 3);

        issue(rtype(7'h00, 3'b010, 5'd7), 32'hFFFF_FFFF, 32'd1);
        wb(5'd7, 32'd1, 1'b0);
        check("slt_exp", CHK_EXP, 1);

        issue(rtype(7'h00, 3'b001, 5'd8), 32'h0000_0003, 32'h0000_0024);
        wb(5'd8, 32'h30, 1'b0);
        check("sll_exp", CHK_EXP, 32'h30);
        check("sll_pcnt", PASS_CNT, 5);

        issue(lui(5'd7), 32'd0, 32'd0);
        wb(5'd8, 32'd0, 1'b0);
        check("rdm_kind", CHK_KIND, K_RDMIS);
        check("rdm_ecnt", ERR_CNT, 2);

        // Fill four entries, the fifth overflows
        for (int i = 0; i < 4; i++)
            issue(lui(5'(10 + i)), 32'd0, 32'd0);
        check("full_level", LEVEL, 4);
        check("full_nochk", CHK_VALID, 0);
        issue(lui(5'd14), 32'd0, 32'd0);
        check("ovf_valid", CHK_VALID, 1);
        check("ovf_kind", CHK_KIND, K_OVF);
        check("ovf_flag", OVF, 1);
        check("ovf_level", LEVEL, 4);
        check("ovf_ecnt", ERR_CNT, 3);
        for (int i = 0; i < 4; i++) begin
            wb(5'(10 + i), 32'h1234_5000, 1'b0);
            check("drain_pass", CHK_PASS, 1);
            check("drain_kind", CHK_KIND, K_NONE);
        end
        check("drain_level", LEVEL, 0);
        check("drain_pcnt", PASS_CNT, 9);
        check("drain_ovf", OVF, 1);

        // Single entry left unanswered
        issue(lui(5'd15), 32'd0, 32'd0);
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            tick();
            if (CHK_VALID) got = 1;
        end
        check("tmo_seen", got, 1);
        check("tmo_kind", CHK_KIND, K_TMO);
        check("tmo_level", LEVEL, 0);
        check("tmo_ecnt", ERR_CNT, 4);
        wb(5'd9, 32'hABCD, 1'b0);
        check("unexp_kind", CHK_KIND, K_UNEXP);
        check("unexp_act", CHK_ACT, 32'hABCD);
        check("unexp_ecnt", ERR_CNT, 5);

        // Writeback plus flush: one pass, rest discarded
        issue(lui(5'd16), 32'd0, 32'd0);
        issue(lui(5'd17), 32'd0, 32'd0);
        check("fl_level2", LEVEL, 2);
        wb(5'd16, 32'h1234_5000, 1'b1);
        check("fl_pass", CHK_PASS, 1);
        check("fl_level", LEVEL, 0);
        check("fl_pcnt", PASS_CNT, 10);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (CHK_VALID) pulses++;
        end
        check("fl_quiet", pulses, 0);

        issue(rtype(7'h00, 3'b000, 5'd0), 32'd1, 32'd1);
        check("x0_nopush", LEVEL, 0);
        issue(rtype(7'h01, 3'b000, 5'd3), 32'd1, 32'd1);
        check("bad_f7", LEVEL, 0);
        wb(5'd0, 32'd5, 1'b0);
        check("wb_x0", CHK_VALID, 0);

        // Reset mid-operation discards silently
        issue(lui(5'd20), 32'd0, 32'd0);
        check("pre_rst", LEVEL, 1);
        RES = 1'b1;
        tick();
        RES = 1'b0;
        check("mid_level", LEVEL, 0);
        check("mid_cnt", {PASS_CNT, ERR_CNT}, 0);
        check("mid_ovf", OVF, 0);
        check("mid_valid", CHK_VALID, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/r_type_retire_tracker.md
Name: r_type_retire_tracker

Overview:
- In-order retirement tracker and reference checker for the darkriscv core.
- Sits alongside the R-type operand/result checks in the bench.
- Captures every accepted instruction that writes a destination register, queues it, and matches it against DUT register-file writebacks.
- For R-type entries it also computes the expected ALU result at issue and compares it at writeback. Each check result is reported as a registered pulse, and error and pass totals are accumulated in counters.

Parameters:
- DEPTH, 4, number of in-flight entries; power of 2, minimum 2.
- TIMEOUT, 16, maximum cycles an entry may wait at head before a timeout error.
- CNT_W, 16, width of the pass/error counters.

Ports:
- CLK  in  1  core clock.
- RES  in  1  synchronous active-high reset.
- IDATA  in  32  instruction word at the execute stage.
- IVALID  in  1  instruction accepted this cycle (not halted, not flushed).
- FLUSH  in  1  pipeline flush.
- RS1_VAL  in  32  rs1 operand as read by the DUT in the IVALID cycle.
- RS2_VAL  in  32  rs2 operand as read by the DUT in the IVALID cycle.
- WB_VALID  in  1  DUT register-file write this cycle.
- WB_RD  in  5  writeback destination.
- WB_DATA  in  32  writeback data.
- CHK_VALID  out  1  one-cycle pulse: a check completed.
- CHK_PASS  out  1  result of that check.
- CHK_KIND  out  3  err_kind_e: NONE, MISMATCH, RD_MISMATCH, UNEXPECTED, TIMEOUT, OVERFLOW.
- CHK_EXP  out  32  expected data, valid only for R-type checks.
- CHK_ACT  out  32  observed data.
- PASS_CNT  out  CNT_W  saturating pass counter.
- ERR_CNT  out  CNT_W  saturating error counter.
- LEVEL  out  $clog2(DEPTH)+1  queue occupancy.
- OVF  out  1  sticky overflow flag.

Behaviour:
- Reset: all outputs are 0, the queue is empty, the FSM is in EMPTY, and the head age counter is 0. Reset applied mid-operation discards all entries with no report.

Capture:
- On IVALID && !FLUSH, an instruction whose opcode writes rd is pushed, provided rd != 0. The opcodes are R, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR.
- An entry holds {rd, is_r, exp}.

R-type decode and expected value:
- Opcode 0110011 sets is_r=1 and exp is taken from r_type_ref_alu.
- Legal encodings: funct7 0000000 for ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND; funct7 0100000 for SUB and SRA.
- Any other funct7 is not pushed.
- Arithmetic is 32-bit modulo; shift amount is RS2_VAL[4:0]; SLT is signed, SLTU is unsigned.

Writeback:
- When WB_VALID && WB_RD != 0, the head entry is popped.
- If WB_RD != head.rd, report RD_MISMATCH.
- Otherwise, if is_r and WB_DATA !== exp, report MISMATCH.
- Otherwise report a pass.
- Writes to x0 are ignored.
- A writeback with the queue empty reports UNEXPECTED and pops nothing.

Outputs and counters:
- All CHK_* outputs are registered, one cycle after the triggering event.
- Any report with CHK_PASS=0 increments ERR_CNT; a pass increments PASS_CNT. Both saturate at all-ones.

Timeout:
- The age counter runs while the queue is non-empty and clears on every pop.
- When age reaches TIMEOUT, the head is popped and TIMEOUT is reported.
- A writeback in the same cycle takes priority over the timeout.

Simultaneous events:
- Push and pop in the same cycle leave LEVEL unchanged; on a full queue this does not overflow.
- A push when full and not popping drops the entry, sets OVF, and reports OVERFLOW.
- If WB_VALID and FLUSH occur together, the writeback is processed first, then all remaining entries are discarded silently. The IVALID capture in that cycle is suppressed.
- Only one report per cycle is produced. Priority: writeback/UNEXPECTED > TIMEOUT > OVERFLOW; a lower-priority event is still counted in ERR_CNT.

FSM:
- EMPTY moves to ACTIVE on push.
- ACTIVE moves to EMPTY when LEVEL reaches 0.
- Any state moves to OVERFLOWED on overflow. OVERFLOWED is sticky until RES, keeps tracking normally, and holds OVF=1.

Decomposition:
- Package r_type_chk_pkg:
  - Opcode constants.
  - funct3/funct7 constants.
  - alu_op_e enum.
  - err_kind_e enum.
  - entry_t struct {rd, is_r, exp}.
- Sub-module r_type_ref_alu: combinational decode of funct3/funct7 to alu_op_e, and computation of exp with a legal flag.
- The queue is a circular buffer inside the top block, with head/tail pointers one bit wider than the index.

Test Plan:
1. ADD x3,x1,x2 with RS1=5, RS2=7, then WB rd=3 data=12 -> CHK_VALID, PASS=1, EXP=12, PASS_CNT=1.
2. SUB x4 with 5-7, then WB data 0xFFFFFFFF -> PASS=0, KIND=MISMATCH, EXP=0xFFFFFFFE, ERR_CNT=1.
3. SRA with RS1=0x80000000 and RS2=4, then WB 0xF8000000 -> pass. SLTU with 1 vs 0xFFFFFFFF -> exp=1.
4. DEPTH=4: five pushes with no WB -> fifth reports OVERFLOW, OVF=1, LEVEL=4. Then four correct WBs -> four passes, LEVEL=0.
5. One push, no WB for 16 cycles -> TIMEOUT reported, LEVEL=0. Then a WB on an empty queue -> UNEXPECTED.
6. Two pushes, then WB of the older entry together with FLUSH -> one pass, LEVEL=0, no further reports. ADD x0 with IVALID -> no push.
